// File: rtl/ant_scent_writer_pkg.sv
// ant_scent_writer_pkg: shared grid/signal widths and the scent writer state enum
package ant_scent_writer_pkg;
  localparam int X_bits = 6;
  localparam int Y_bits = 6;
  localparam int SIGNAL_bits = 8;
  typedef enum logic [2:0] {IDLE, SCAN, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/ant_scent_writer_scent_adder.sv
// scent_adder: cell value plus deposit, wrapping by default or clamped when ANT_SCENT_SATURATE_EN is defined
module scent_adder #(
  parameter int SIGNAL_bits = ant_scent_writer_pkg::SIGNAL_bits,
  parameter logic [SIGNAL_bits-1:0] DEPOSIT = 8'h20
) (
  input  logic [SIGNAL_bits-1:0] i_a,
  output logic [SIGNAL_bits-1:0] o_sum
);
`ifdef ANT_SCENT_SATURATE_EN
  logic [SIGNAL_bits:0] w_sum;
  assign w_sum = {1'b0, i_a} + {1'b0, DEPOSIT};
  assign o_sum = w_sum[SIGNAL_bits] ? '1 : w_sum[SIGNAL_bits-1:0];
`else
  assign o_sum = i_a + DEPOSIT;
`endif
endmodule

// File: rtl/ant_scent_writer.sv
// ant_scent_writer: once per round, adds DEPOSIT to the grid cell under each food-carrying ant (ANT_SCENT_SATURATE_EN selects clamping)
module ant_scent_writer #(
  parameter int N_ANTS = 8,
  parameter int X_bits = ant_scent_writer_pkg::X_bits,
  parameter int Y_bits = ant_scent_writer_pkg::Y_bits,
  parameter int SIGNAL_bits = ant_scent_writer_pkg::SIGNAL_bits,
  parameter logic [SIGNAL_bits-1:0] DEPOSIT = 8'h20
) (
  input  logic                              game_clk,
  input  logic                              RESET_N,
  input  logic                              move_done,
  input  logic [N_ANTS-1:0][X_bits-1:0]     ant_X,
  input  logic [N_ANTS-1:0][Y_bits-1:0]     ant_Y,
  input  logic [N_ANTS-1:0]                 ant_mouthFull,
  output logic [X_bits-1:0]                 mem_x,
  output logic [Y_bits-1:0]                 mem_y,
  output logic                              mem_rd_en,
  input  logic [SIGNAL_bits-1:0]            mem_rd_data,
  output logic                              mem_wr_en,
  output logic [SIGNAL_bits-1:0]            mem_wr_data,
  output logic                              busy,
  output logic                              global_writing_flag
);
  import ant_scent_writer_pkg::*;
  localparam int IW = N_ANTS > 1 ? $clog2(N_ANTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_ANTS - 1);
  state_t                          r_state;
  state_t                          w_next;
  logic [IW-1:0]                   r_idx;
  logic [N_ANTS-1:0][X_bits-1:0]   r_x;
  logic [N_ANTS-1:0][Y_bits-1:0]   r_y;
  logic [N_ANTS-1:0]               r_mf;
  logic                            r_flag;
  logic                            w_last;
  logic                            w_acc;
  logic [SIGNAL_bits-1:0]          w_sum;
  assign w_last = r_idx == LAST;
  assign w_acc = r_state == READ || r_state == WRITE;
  // next state: walk the snapshot, detour through READ/WRITE for each carrying ant
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = move_done ? SCAN : IDLE;
      SCAN:    w_next = r_mf[r_idx] ? READ : (w_last ? DONE : SCAN);
      READ:    w_next = WRITE;
      WRITE:   w_next = w_last ? DONE : SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, ant index, snapshot of ant inputs, and the round-end flag (one cycle after DONE)
  always_ff @(posedge game_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_mf    <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flag  <= r_state == DONE;
      if (r_state == IDLE && move_done) begin
        r_idx <= '0;
        r_x   <= ant_X;
        r_y   <= ant_Y;
        r_mf  <= ant_mouthFull;
      end else if ((r_state == SCAN && !r_mf[r_idx] && !w_last) || (r_state == WRITE && !w_last)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
  scent_adder #(.SIGNAL_bits(SIGNAL_bits), .DEPOSIT(DEPOSIT)) u_adder (
    .i_a   (mem_rd_data),
    .o_sum (w_sum)
  );
  assign busy                = r_state != IDLE;
  assign mem_rd_en           = r_state == READ;
  assign mem_wr_en           = r_state == WRITE;
  assign mem_x               = w_acc ? r_x[r_idx] : '0;
  assign mem_y               = w_acc ? r_y[r_idx] : '0;
  assign mem_wr_data         = mem_wr_en ? w_sum : '0;
  assign global_writing_flag = r_flag;
endmodule

// File: tb/tb_ant_scent_writer.sv
// tb_ant_scent_writer: directed and random rounds against a grid model for ant_scent_writer (N_ANTS=4)
module tb_ant_scent_writer;
  logic            game_clk = 1'b0;
  logic            RESET_N;
  logic            move_done;
  logic [3:0][5:0] ant_X;
  logic [3:0][5:0] ant_Y;
  logic [3:0]      ant_mouthFull;
  logic [5:0]      mem_x;
  logic [5:0]      mem_y;
  logic            mem_rd_en;
  logic [7:0]      mem_rd_data = 8'h00;
  logic            mem_wr_en;
  logic [7:0]      mem_wr_data;
  logic            busy;
  logic            global_writing_flag;

  ant_scent_writer #(.N_ANTS(4)) dut (
    .game_clk            (game_clk),
    .RESET_N             (RESET_N),
    .move_done           (move_done),
    .ant_X               (ant_X),
    .ant_Y               (ant_Y),
    .ant_mouthFull       (ant_mouthFull),
    .mem_x               (mem_x),
    .mem_y               (mem_y),
    .mem_rd_en           (mem_rd_en),
    .mem_rd_data         (mem_rd_data),
    .mem_wr_en           (mem_wr_en),
    .mem_wr_data         (mem_wr_data),
    .busy                (busy),
    .global_writing_flag (global_writing_flag)
  );

  always #5 game_clk = ~game_clk;

  logic [7:0]  grid [64][64];
  int          mdl  [64][64];
  logic [11:0] exp_rd[$];
  logic [11:0] obs_rd[$];
  logic [19:0] exp_wr[$];
  logic [19:0] obs_wr[$];
  int overlap, pass_cnt, fail_cnt, total, lat, fcnt, bcnt, ncar;

  // signal-grid memory: read data appears after the read strobe and holds through the next cycle
  always @(negedge game_clk) begin
    if (mem_rd_en && mem_wr_en) overlap++;
    if (mem_rd_en) begin
      mem_rd_data = grid[mem_x][mem_y];
      obs_rd.push_back({mem_x, mem_y});
    end
    if (mem_wr_en) begin
      grid[mem_x][mem_y] = mem_wr_data;
      obs_wr.push_back({mem_x, mem_y, mem_wr_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int deposit(input int old);
    int nv;
    nv = old + 32;
`ifdef ANT_SCENT_SATURATE_EN
    return nv > 255 ? 255 : nv;
`else
    return nv % 256;
`endif
  endfunction

  task automatic run_round(input string tag, input bit disturb);
    logic [5:0] x, y;
    int nv;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) mdl[i][j] = int'(grid[i][j]);
    exp_rd.delete(); exp_wr.delete(); ncar = 0;
    for (int i = 0; i < 4; i++) begin
      if (ant_mouthFull[i]) begin
        ncar++;
        x = ant_X[i];
        y = ant_Y[i];
        nv = deposit(mdl[x][y]);
        mdl[x][y] = nv;
        exp_rd.push_back({x, y});
        exp_wr.push_back({x, y, nv[7:0]});
      end
    end
    obs_rd.delete(); obs_wr.delete(); overlap = 0;
    lat = 0; fcnt = 0; bcnt = 0;
    @(negedge game_clk);
    move_done = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge game_clk);
      if (busy) bcnt++;
      if (global_writing_flag) begin
        fcnt++;
        if (lat == 0) lat = cyc;
      end
      move_done = disturb && cyc == 3;
      if (disturb && cyc == 3) begin
        ant_X = 24'($urandom);
        ant_Y = 24'($urandom);
        ant_mouthFull = 4'($urandom);
      end
      if (lat != 0 && cyc >= lat + 3) break;
    end
    check({tag, "_latency"}, lat, 6 + 2 * ncar);
    check({tag, "_flag_count"}, fcnt, 1);
    check({tag, "_busy_cycles"}, bcnt, 5 + 2 * ncar);
    check({tag, "_rd_wr_overlap"}, overlap, 0);
    check({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
    check({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) begin
      check({tag, "_rd_addr"}, i < obs_rd.size() ? obs_rd[i] : 12'hfff, exp_rd[i]);
      check({tag, "_wr_entry"}, i < obs_wr.size() ? obs_wr[i] : 20'hfffff, exp_wr[i]);
      check({tag, "_cell"}, grid[exp_wr[i][19:14]][exp_wr[i][13:8]], mdl[exp_wr[i][19:14]][exp_wr[i][13:8]]);
    end
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) grid[i][j] = 8'h00;
    RESET_N = 1'b0; move_done = 1'b0;
    ant_X = '0; ant_Y = '0; ant_mouthFull = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_flag", global_writing_flag, 0);
    check("rst_addr", {mem_x, mem_y}, 0);
    check("rst_wr_data", mem_wr_data, 0);
    repeat (3) @(negedge game_clk);
    RESET_N = 1'b1;
    repeat (4) @(negedge game_clk);
    check("idle_after_reset", {busy, global_writing_flag}, 0);

    ant_mouthFull = 4'b0000;
    run_round("none_carrying", 1'b0);

    ant_X = '0; ant_Y = '0;
    ant_X[2] = 6'd5; ant_Y[2] = 6'd7; ant_mouthFull = 4'b0100;
    grid[5][7] = 8'h10;
    run_round("single_ant", 1'b0);
    check("single_ant_latency_abs", lat, 8);
    check("single_ant_wr", obs_wr.size() > 0 ? obs_wr[0] : 20'h0, {6'd5, 6'd7, 8'h30});

    ant_X = '0; ant_Y = '0;
    ant_X[0] = 6'd1; ant_Y[0] = 6'd1; ant_X[3] = 6'd1; ant_Y[3] = 6'd1;
    ant_mouthFull = 4'b1001;
    grid[1][1] = 8'h00;
    run_round("same_cell", 1'b0);
    check("same_cell_final", grid[1][1], 8'h40);

    ant_X = '0; ant_Y = '0;
    ant_X[1] = 6'd9; ant_Y[1] = 6'd9; ant_mouthFull = 4'b0010;
    grid[9][9] = 8'hF0;
    run_round("overflow", 1'b0);
`ifdef ANT_SCENT_SATURATE_EN
    check("overflow_value", grid[9][9], 8'hFF);
`else
    check("overflow_value", grid[9][9], 8'h10);
`endif

    ant_X = '0; ant_Y = '0;
    ant_X[0] = 6'd3; ant_Y[0] = 6'd4; ant_X[2] = 6'd6; ant_Y[2] = 6'd1;
    ant_mouthFull = 4'b0101;
    run_round("ignore_inputs", 1'b1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) grid[i][j] = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        ant_X[i] = 6'($urandom_range(0, 3));
        ant_Y[i] = 6'($urandom_range(0, 3));
      end
      ant_mouthFull = 4'($urandom);
      run_round("random", 1'b0);
    end

    ant_X = '0; ant_Y = '0;
    ant_X[0] = 6'd2; ant_Y[0] = 6'd3; ant_mouthFull = 4'b0001;
    grid[2][3] = 8'h55;
    @(negedge game_clk);
    move_done = 1'b1;
    @(negedge game_clk);
    move_done = 1'b0;
    for (int k = 0; k < 10 && !mem_rd_en; k++) @(negedge game_clk);
    check("abort_reached_read", mem_rd_en, 1);
    RESET_N = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_strobes", {mem_rd_en, mem_wr_en, global_writing_flag}, 0);
    check("abort_addr_data", {mem_x, mem_y, mem_wr_data}, 0);
    repeat (2) @(negedge game_clk);
    RESET_N = 1'b1;
    obs_rd.delete(); obs_wr.delete(); fcnt = 0; bcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge game_clk);
      if (global_writing_flag) fcnt++;
      if (busy) bcnt++;
    end
    check("abort_no_flag", fcnt, 0);
    check("abort_no_busy", bcnt, 0);
    check("abort_no_strobes", obs_rd.size() + obs_wr.size(), 0);
    check("abort_cell_kept", grid[2][3], 8'h55);
    run_round("after_abort", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
